// File: rtl/mac_tx_arbiter.sv
// Round-robin packet arbiter sharing one 10GE MAC transmit interface between NUM_SRC sources.
// Define MAC_TX_ARB_STATS_EN to build the per-source sent-packet counters on pkt_cnt.
module mac_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int MIN_GAP = 0
) (
  input  logic                         clk_156m25,
  input  logic                         reset_156m25_n,
  input  logic [NUM_SRC-1:0]           src_val,
  input  logic [NUM_SRC-1:0]           src_sop,
  input  logic [NUM_SRC-1:0]           src_eop,
  input  logic [3*NUM_SRC-1:0]         src_mod,
  input  logic [64*NUM_SRC-1:0]        src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [63:0]                  pkt_tx_data,
  output logic                         pkt_tx_val,
  output logic                         pkt_tx_sop,
  output logic                         pkt_tx_eop,
  output logic [2:0]                   pkt_tx_mod,
  input  logic                         pkt_tx_full,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         proto_err,
  output logic [32*NUM_SRC-1:0]        pkt_cnt
);

  localparam int unsigned N  = NUM_SRC;
  localparam int unsigned GW = $clog2(NUM_SRC);
  localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] last;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;
  logic [GW-1:0] sel;
  logic [3:0]    gap_cnt;
  logic [N-1:0]  cand;
  logic [N-1:0]  discard;
  logic [N-1:0]  ready;
  logic          cand_any;
  logic          acc;
  logic          sel_sop;
  logic          sel_eop;
  logic [63:0]   data_a [N];
  logic [2:0]    mod_a  [N];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      data_a[i] = src_data[i*64 +: 64];
      mod_a[i]  = src_mod[i*3 +: 3];
    end
  end

  // Search order starts just after the last winner and wraps modulo NUM_SRC.
  always_comb begin
    cand     = src_val & src_sop;
    cand_any = 1'b0;
    pick     = '0;
    idx      = last;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (idx == GW'(N - 1)) ? '0 : idx + GW'(1);
      if (!cand_any && cand[idx]) begin
        cand_any = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    acc     = 1'b0;
    ready   = '0;
    discard = '0;
    sel     = grant_id;
    case (state)
      IDLE: begin
        sel     = pick;
        discard = src_val & ~src_sop;
        acc     = cand_any & ~pkt_tx_full;
        ready   = discard;
        if (acc) ready[pick] = 1'b1;
      end
      SEND: begin
        acc             = src_val[grant_id] & ~pkt_tx_full;
        ready[grant_id] = acc;
      end
      default: ;
    endcase
    sel_sop = src_sop[sel];
    sel_eop = src_eop[sel];
  end

  assign src_ready = reset_156m25_n ? ready : '0;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      last        <= GW'(N - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
      gap_cnt     <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_data <= '0;
      pkt_tx_mod  <= '0;
    end else begin
      pkt_tx_val <= acc;
      pkt_tx_sop <= acc & sel_sop;
      pkt_tx_eop <= acc & sel_eop;
      if (acc) begin
        pkt_tx_data <= data_a[sel];
        pkt_tx_mod  <= mod_a[sel];
      end
      if (|discard) proto_err <= 1'b1;
      case (state)
        IDLE: if (acc) begin
          grant_id <= pick;
          last     <= pick;
          busy     <= ~sel_eop;
          if (!sel_eop) begin
            state <= SEND;
          end else if (MIN_GAP > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        SEND: if (acc) begin
          if (sel_sop) proto_err <= 1'b1;
          if (sel_eop) begin
            busy <= 1'b0;
            if (MIN_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_TX_ARB_STATS_EN
  logic [31:0] cnt [N];

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else if (acc && sel_eop) begin
      cnt[sel] <= cnt[sel] + 32'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < N; i++) pkt_cnt[i*32 +: 32] = cnt[i];
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: queued source beats, expected MAC beats checked by a monitor.
module tb_mac_tx_arbiter;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   src_val = '0, src_sop = '0, src_eop = '0;
  logic [11:0]  src_mod = '0;
  logic [255:0] src_data = '0;
  logic [3:0]   src_ready;
  logic [63:0]  pkt_tx_data;
  logic         pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]   pkt_tx_mod;
  logic         pkt_tx_full = 1'b0;
  logic [1:0]   grant_id;
  logic         busy, proto_err;
  logic [127:0] pkt_cnt;

  logic [1:0]   g_val = '0, g_sop = '0, g_eop = '0;
  logic [5:0]   g_mod = '0;
  logic [127:0] g_data = '0;
  logic [1:0]   g_ready;
  logic [63:0]  g_tx_data;
  logic         g_tx_val, g_tx_sop, g_tx_eop;
  logic [2:0]   g_tx_mod;
  logic [0:0]   g_grant;
  logic         g_busy, g_perr;
  logic [63:0]  g_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int vcnt = 0;
  beat_t sq [4][$];
  beat_t expq [$];

  always #5 clk = ~clk;

  mac_tx_arbiter #(.NUM_SRC(4), .MIN_GAP(0)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .src_val(src_val), .src_sop(src_sop), .src_eop(src_eop), .src_mod(src_mod),
    .src_data(src_data), .src_ready(src_ready),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
  );

  mac_tx_arbiter #(.NUM_SRC(2), .MIN_GAP(3)) dut_g (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .src_val(g_val), .src_sop(g_sop), .src_eop(g_eop), .src_mod(g_mod),
    .src_data(g_data), .src_ready(g_ready),
    .pkt_tx_data(g_tx_data), .pkt_tx_val(g_tx_val), .pkt_tx_sop(g_tx_sop),
    .pkt_tx_eop(g_tx_eop), .pkt_tx_mod(g_tx_mod), .pkt_tx_full(1'b0),
    .grant_id(g_grant), .busy(g_busy), .proto_err(g_perr), .pkt_cnt(g_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source driver: present queue heads at negedge, consume those still ready just before the edge.
  initial begin
    logic [3:0] rdy;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sq[i].size() > 0) begin
          src_val[i] = 1'b1;
          src_sop[i] = sq[i][0].sop;
          src_eop[i] = sq[i][0].eop;
          src_mod[3*i +: 3]   = sq[i][0].mod;
          src_data[64*i +: 64] = sq[i][0].d;
        end else begin
          src_val[i] = 1'b0;
          src_sop[i] = 1'b0;
          src_eop[i] = 1'b0;
        end
      end
      #4;
      rdy = src_ready;
      for (int i = 0; i < 4; i++)
        if (rdy[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    end
  end

  // Monitor: every MAC beat must match the next expected beat.
  initial begin
    beat_t a, e;
    forever begin
      @(negedge clk);
      if (pkt_tx_val === 1'b1) begin
        vcnt++;
        a = '{d: pkt_tx_data, sop: pkt_tx_sop, eop: pkt_tx_eop, mod: pkt_tx_mod};
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", a);
        end else begin
          e = expq.pop_front();
          check("mac_beat", 128'(a), 128'(e));
        end
      end
    end
  end

  function automatic int pending();
    return expq.size() + sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size();
  endfunction

  task automatic push(input int s, input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] mod, input bit expect_out);
    beat_t b;
    b = '{d: d, sop: sop, eop: eop, mod: mod};
    sq[s].push_back(b);
    if (expect_out) expq.push_back(b);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (pending() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(name, 128'(pending()), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    int run, t0, t1, k;
    logic [1:0] r;

    // Reset state while four single-beat packets are already waiting.
    for (int i = 0; i < 4; i++) push(i, 64'h10 + 64'(i), 1'b1, 1'b1, 3'(i + 1), 1'b1);
    @(negedge clk);
    #2;
    check("rst_ready", src_ready, 4'b0);
    check("rst_outs", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}, '0);
    check("rst_status", {busy, grant_id, proto_err}, '0);
    check("rst_cnt", pkt_cnt, '0);
    check("rst_g_outs", {g_tx_val, g_busy, g_perr, g_ready}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_drain("rst_rr_order");

    // Test 1: three-beat packet from source 2.
    do_reset();
    push(2, 64'hA0, 1'b1, 1'b0, 3'd0, 1'b1);
    push(2, 64'hA1, 1'b0, 1'b0, 3'd0, 1'b1);
    push(2, 64'hA2, 1'b0, 1'b1, 3'd5, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy && !seen) begin
        seen = 1'b1;
        check("t1_grant", grant_id, 2'd2);
      end
    end
    check("t1_busy_seen", seen, 1'b1);
    wait_drain("t1_drain");
`ifdef MAC_TX_ARB_STATS_EN
    check("t1_cnt2", pkt_cnt[95:64], 32'd1);
`else
    check("t1_cnt_off", pkt_cnt, '0);
`endif

    // Test 2: four two-beat packets back to back.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      push(s, 64'h20 + 64'(2*s), 1'b1, 1'b0, 3'd0, 1'b1);
      push(s, 64'h21 + 64'(2*s), 1'b0, 1'b1, 3'd3, 1'b1);
    end
    k = 0;
    while (pkt_tx_val !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    run = 0;
    while (pkt_tx_val === 1'b1 && run < 20) begin
      run++;
      @(negedge clk);
    end
    check("t2_no_bubbles", 128'(run), 128'(8));
    wait_drain("t2_drain");
`ifdef MAC_TX_ARB_STATS_EN
    check("t2_cnt", pkt_cnt, {32'd1, 32'd1, 32'd1, 32'd1});
`else
    check("t2_cnt_off", pkt_cnt, '0);
`endif

    // Test 3: backpressure for four cycles mid-packet.
    do_reset();
    for (int b = 0; b < 4; b++)
      push(1, 64'h30 + 64'(b), b == 0, b == 3, (b == 3) ? 3'd7 : 3'd0, 1'b1);
    k = 0;
    while (!(pkt_tx_val === 1'b1 && pkt_tx_sop === 1'b1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    pkt_tx_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      check("t3_ready_held", src_ready, 4'b0);
      @(negedge clk);
      check("t3_paused", pkt_tx_val, 1'b0);
    end
    pkt_tx_full = 1'b0;
    wait_drain("t3_drain");

    // Test 4: MIN_GAP=3 between two single-beat packets.
    do_reset();
    @(negedge clk);
    g_data = {64'hB1, 64'hB0};
    g_sop = 2'b11;
    g_eop = 2'b11;
    g_val = 2'b11;
    t0 = -1;
    t1 = -1;
    for (int c = 0; c < 30; c++) begin
      #4 r = g_ready;
      @(negedge clk);
      g_val = g_val & ~r;
      if (g_tx_val === 1'b1) begin
        if (t0 < 0) begin
          t0 = c;
          check("t4_first", g_tx_data, 64'hB0);
        end else if (t1 < 0) begin
          t1 = c;
          check("t4_second", g_tx_data, 64'hB1);
        end
      end
    end
    check("t4_idle_gap", 128'(t1 - t0 - 1), 128'(3));

    // Test 5: val without sop while idle is discarded and flagged.
    do_reset();
    push(1, 64'h50, 1'b0, 1'b0, 3'd0, 1'b0);
    wait_drain("t5_discard");
    check("t5_perr", proto_err, 1'b1);
    push(0, 64'h51, 1'b1, 1'b1, 3'd1, 1'b1);
    wait_drain("t5_next_pkt");
    check("t5_perr_sticky", proto_err, 1'b1);

    // Test 6: asynchronous reset during beat 2 of 5.
    do_reset();
    for (int b = 0; b < 5; b++)
      push(0, 64'h60 + 64'(b), b == 0, b == 4, (b == 4) ? 3'd2 : 3'd0, b < 2);
    k = 0;
    while (!(pkt_tx_val === 1'b1 && pkt_tx_data === 64'h61) && k < 20) begin
      @(negedge clk);
      k++;
    end
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_outs", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data}, '0);
    check("t6_async_status", {busy, grant_id, src_ready}, '0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    wait_drain("t6_stale_discard");
    check("t6_perr", proto_err, 1'b1);
    push(3, 64'h70, 1'b1, 1'b1, 3'd4, 1'b0);
    push(0, 64'h71, 1'b1, 1'b1, 3'd6, 1'b1);
    expq.push_back('{d: 64'h70, sop: 1'b1, eop: 1'b1, mod: 3'd4});
    wait_drain("t6_src0_priority");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
